// File: rtl/btb_update_writer_pkg.sv
// Shared BTB update types, widths and the PC/ASID field hash used by both the
// lookup and write sides of the BTB.
package btb_update_writer_pkg;

  localparam int unsigned UPDATE_QUEUE_DEPTH             = 4;
  localparam int unsigned BTB_INDEX_WIDTH                = 7;
  localparam int unsigned LOG_BTB_NWAY_ENTRIES_PER_BLOCK = 3;
  localparam int unsigned BTB_TAG_WIDTH                  = 6;
  localparam int unsigned ASID_WIDTH                     = 9;
  localparam int unsigned BTB_TARGET_WIDTH               = 10;
  localparam int unsigned BTB_INFO_WIDTH                 = 3;

  // First PC bit above the index field; the tag folds two slices from here up.
  localparam int unsigned BTB_HASH_LSB = BTB_INDEX_WIDTH + LOG_BTB_NWAY_ENTRIES_PER_BLOCK + 1;

  typedef struct packed {
    logic [BTB_INDEX_WIDTH-1:0]                index;
    logic [LOG_BTB_NWAY_ENTRIES_PER_BLOCK-1:0] entry;
    logic [BTB_TAG_WIDTH-1:0]                  tag;
    logic [BTB_TARGET_WIDTH-1:0]               target;
    logic [BTB_INFO_WIDTH-1:0]                 info;
  } btb_update_entry_t;

  typedef enum logic {
    NORMAL,
    CLEAR
  } btb_update_writer_state_t;

  // Right shifts of the 32-bit PC naturally read bits above 31 as zero.
  function automatic btb_update_entry_t btb_update_fields(
    input logic [31:0]                 pc,
    input logic [ASID_WIDTH-1:0]       asid,
    input logic [BTB_TARGET_WIDTH-1:0] target,
    input logic [BTB_INFO_WIDTH-1:0]   info
  );
    btb_update_entry_t e;
    e.entry  = LOG_BTB_NWAY_ENTRIES_PER_BLOCK'(pc >> 1);
    e.index  = BTB_INDEX_WIDTH'(pc >> (LOG_BTB_NWAY_ENTRIES_PER_BLOCK + 1));
    e.tag    = BTB_TAG_WIDTH'(pc >> BTB_HASH_LSB)
             ^ BTB_TAG_WIDTH'(pc >> (BTB_HASH_LSB + BTB_TAG_WIDTH))
             ^ BTB_TAG_WIDTH'(asid);
    e.target = target;
    e.info   = info;
    return e;
  endfunction

endpackage

// File: rtl/btb_update_writer_if.sv
// Update-request, sweep-control and BTB array write-port signals of the
// update writer; slave is the writer, master is its environment.
interface btb_update_writer_if;
  import btb_update_writer_pkg::*;

  logic                                      upd_valid;
  logic                                      upd_ready;
  logic [31:0]                               upd_PC;
  logic [ASID_WIDTH-1:0]                     upd_ASID;
  logic [BTB_TARGET_WIDTH-1:0]               upd_target;
  logic [BTB_INFO_WIDTH-1:0]                 upd_info;
  logic                                      clr_req;
  logic                                      clr_done;
  logic                                      wr_valid;
  logic                                      wr_ready;
  logic                                      wr_clear;
  logic [BTB_INDEX_WIDTH-1:0]                wr_index;
  logic [LOG_BTB_NWAY_ENTRIES_PER_BLOCK-1:0] wr_entry;
  logic [BTB_TAG_WIDTH-1:0]                  wr_tag;
  logic [BTB_TARGET_WIDTH-1:0]               wr_target;
  logic [BTB_INFO_WIDTH-1:0]                 wr_info;

  modport master (
    output upd_valid, upd_PC, upd_ASID, upd_target, upd_info, clr_req, wr_ready,
    input  upd_ready, clr_done, wr_valid, wr_clear, wr_index, wr_entry, wr_tag,
           wr_target, wr_info
  );

  modport slave (
    input  upd_valid, upd_PC, upd_ASID, upd_target, upd_info, clr_req, wr_ready,
    output upd_ready, clr_done, wr_valid, wr_clear, wr_index, wr_entry, wr_tag,
           wr_target, wr_info
  );

endinterface

// File: rtl/btb_update_fifo.sv
// Valid/ready FIFO of BTB update entries with synchronous flush and an
// in-place target/info overwrite of the youngest entry.
module btb_update_fifo
  import btb_update_writer_pkg::*;
#(
  parameter int unsigned Depth = UPDATE_QUEUE_DEPTH
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        i_flush,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  btb_update_entry_t           i_in_data,
  input  logic                        i_ovr_valid,
  input  logic [BTB_TARGET_WIDTH-1:0] i_ovr_target,
  input  logic [BTB_INFO_WIDTH-1:0]   i_ovr_info,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output btb_update_entry_t           o_out_data,
  output btb_update_entry_t           o_tail_data,
  output logic                        o_tail_is_head
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0]   PtrOne  = (AW + 1)'(1);
  localparam logic [AW-1:0] AddrOne = AW'(1);

  // Extra MSB on each pointer separates full from empty.
  logic [AW:0]       r_wptr, r_rptr;
  btb_update_entry_t r_mem [Depth];

  logic          w_full, w_empty, w_push, w_pop;
  logic [AW-1:0] w_tail_addr;

  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push      = i_in_valid && !w_full;
  assign w_pop       = !w_empty && i_out_ready;
  assign w_tail_addr = r_wptr[AW-1:0] - AddrOne;

  assign o_in_ready     = !w_full;
  assign o_out_valid    = !w_empty;
  assign o_out_data     = r_mem[r_rptr[AW-1:0]];
  assign o_tail_data    = r_mem[w_tail_addr];
  assign o_tail_is_head = ((r_wptr - r_rptr) == PtrOne);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrOne;
      if (w_pop)  r_rptr <= r_rptr + PtrOne;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_in_data;
    end else if (i_ovr_valid && !w_empty) begin
      r_mem[w_tail_addr].target <= i_ovr_target;
      r_mem[w_tail_addr].info   <= i_ovr_info;
    end
  end

endmodule

// File: rtl/btb_update_writer.sv
// BTB write-port driver: queues resolved-branch updates and runs full-array
// invalidation sweeps. Optional macro BTB_UPDATE_COALESCE_EN merges repeat updates.
module btb_update_writer
  import btb_update_writer_pkg::*;
(
  input  logic               CLK,
  input  logic               nRST,
  btb_update_writer_if.slave bus
);

  localparam logic [BTB_INDEX_WIDTH-1:0] CntLast = '1;

  btb_update_writer_state_t   r_state;
  logic [BTB_INDEX_WIDTH-1:0] r_cnt;
  logic                       r_clr_done;

  btb_update_entry_t w_new, w_head, w_tail, w_wr;
  logic w_normal, w_fifo_in_ready, w_fifo_out_valid, w_tail_is_head;
  logic w_deq, w_accept, w_match, w_push, w_ovr;

  assign w_normal = (r_state == NORMAL);
  assign w_new    = btb_update_fields(bus.upd_PC, bus.upd_ASID, bus.upd_target, bus.upd_info);
  assign w_deq    = w_normal && w_fifo_out_valid && bus.wr_ready;
  // A handshake coinciding with clr_req is dropped along with the flushed queue.
  assign w_accept = bus.upd_valid && bus.upd_ready && !bus.clr_req;

`ifdef BTB_UPDATE_COALESCE_EN
  assign w_match = w_fifo_out_valid
                && (w_tail.index == w_new.index)
                && (w_tail.entry == w_new.entry)
                && (w_tail.tag == w_new.tag)
                && !(w_tail_is_head && w_deq);
`else
  logic w_unused_tail;
  assign w_unused_tail = ^{w_tail, w_tail_is_head};
  assign w_match       = 1'b0;
`endif

  assign w_push = w_accept && !w_match;
  assign w_ovr  = w_accept && w_match;

  btb_update_fifo #(
    .Depth(UPDATE_QUEUE_DEPTH)
  ) u_fifo (
    .CLK           (CLK),
    .nRST          (nRST),
    .i_flush       (bus.clr_req),
    .i_in_valid    (w_push),
    .o_in_ready    (w_fifo_in_ready),
    .i_in_data     (w_new),
    .i_ovr_valid   (w_ovr),
    .i_ovr_target  (w_new.target),
    .i_ovr_info    (w_new.info),
    .o_out_valid   (w_fifo_out_valid),
    .i_out_ready   (w_normal && bus.wr_ready),
    .o_out_data    (w_head),
    .o_tail_data   (w_tail),
    .o_tail_is_head(w_tail_is_head)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= NORMAL;
      r_cnt      <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_clr_done <= 1'b0;
      if (bus.clr_req) begin
        r_state <= CLEAR;
        r_cnt   <= '0;
      end else if (r_state == CLEAR && bus.wr_ready) begin
        if (r_cnt == CntLast) begin
          r_state    <= NORMAL;
          r_cnt      <= '0;
          r_clr_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_wr = '0;
    if (w_normal) begin
      if (w_fifo_out_valid) w_wr = w_head;
    end else begin
      w_wr.index = r_cnt;
    end
  end

  assign bus.upd_ready = w_normal && w_fifo_in_ready;
  assign bus.clr_done  = r_clr_done;
  assign bus.wr_valid  = w_normal ? w_fifo_out_valid : 1'b1;
  assign bus.wr_clear  = !w_normal;
  assign bus.wr_index  = w_wr.index;
  assign bus.wr_entry  = w_wr.entry;
  assign bus.wr_tag    = w_wr.tag;
  assign bus.wr_target = w_wr.target;
  assign bus.wr_info   = w_wr.info;

endmodule

// File: tb/tb_btb_update_writer.sv
// Self-checking bench for btb_update_writer: table vectors, directed sweep
// sequences and randomized traffic against a queue-based reference model.
module tb_btb_update_writer;
  import btb_update_writer_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  btb_update_writer_if bus ();

  btb_update_writer dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  typedef struct packed {
    logic [6:0] idx;
    logic [2:0] ent;
    logic [5:0] tag;
    logic [9:0] tgt;
    logic [2:0] inf;
  } wr_t;

  typedef struct {
    logic [31:0] pc;
    logic [8:0]  asid;
    logic [9:0]  tgt;
    logic [2:0]  inf;
    logic [6:0]  idx;
    logic [2:0]  ent;
    logic [5:0]  tag;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model
  wr_t mq[$];
  bit  m_clear;
  int  m_cnt;
  bit  m_done;

  // Observed DUT activity
  int obs_acc, obs_wr, obs_clr_wr, obs_done, obs_last_clr_idx, obs_clear_cyc;
  logic [9:0] obs_tgt[$];

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic wr_t mk(logic [31:0] pc, logic [8:0] asid, logic [9:0] tgt, logic [2:0] inf);
    int unsigned p;
    int unsigned a;
    wr_t w;
    p = pc;
    a = asid;
    w.idx = 7'((p / 16) % 128);
    w.ent = 3'((p / 2) % 8);
    w.tag = 6'(((p / 2048) ^ (p / 131072) ^ a) % 64);
    w.tgt = tgt;
    w.inf = inf;
    return w;
  endfunction

  function automatic logic [32:0] m_out();
    wr_t h;
    logic rdy, vld, clr;
    h = '0;
    if (m_clear) begin
      rdy = 1'b0; vld = 1'b1; clr = 1'b1;
      h.idx = 7'(m_cnt);
    end else begin
      rdy = (mq.size() < 4); vld = (mq.size() > 0); clr = 1'b0;
      if (vld) h = mq[0];
    end
    return {rdy, m_done, vld, clr, h};
  endfunction

  function automatic logic [32:0] dut_out();
    return {bus.upd_ready, bus.clr_done, bus.wr_valid, bus.wr_clear, bus.wr_index,
            bus.wr_entry, bus.wr_tag, bus.wr_target, bus.wr_info};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_clear = 1'b0;
    m_cnt   = 0;
    m_done  = 1'b0;
  endtask

  // One clock: drive inputs at a negedge, check, advance model, wait next negedge.
  task automatic cycle(string name, bit v, logic [31:0] pc, logic [8:0] asid,
                       logic [9:0] tgt, logic [2:0] inf, bit clr, bit wrr);
    logic [32:0] got, exp;
    bit hs, gr, coal, done_n;
    wr_t n, t;
    bus.upd_valid  = v;
    bus.upd_PC     = pc;
    bus.upd_ASID   = asid;
    bus.upd_target = tgt;
    bus.upd_info   = inf;
    bus.clr_req    = clr;
    bus.wr_ready   = wrr;
    got = dut_out();
    exp = m_out();
    if (!exp[30]) got[28:0] = '0;
    chk(name, 64'(got), 64'(exp));

    if (bus.upd_valid && bus.upd_ready) obs_acc++;
    if (bus.wr_valid && bus.wr_ready) begin
      obs_wr++;
      if (bus.wr_clear) begin
        obs_clr_wr++;
        obs_last_clr_idx = int'(bus.wr_index);
      end else begin
        obs_tgt.push_back(bus.wr_target);
      end
    end
    if (bus.wr_clear) obs_clear_cyc++;
    if (bus.clr_done) obs_done++;

    hs = v && exp[32];
    gr = exp[30] && wrr;
    done_n = 1'b0;
    if (clr) begin
      mq.delete();
      m_clear = 1'b1;
      m_cnt   = 0;
    end else if (m_clear) begin
      if (wrr) begin
        if (m_cnt == 127) begin
          m_clear = 1'b0;
          m_cnt   = 0;
          done_n  = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end else begin
      n = mk(pc, asid, tgt, inf);
      coal = 1'b0;
`ifdef BTB_UPDATE_COALESCE_EN
      if (hs && mq.size() > 0) begin
        t = mq[mq.size()-1];
        if (t.idx == n.idx && t.ent == n.ent && t.tag == n.tag && !(mq.size() == 1 && gr))
          coal = 1'b1;
      end
`endif
      if (gr) void'(mq.pop_front());
      if (hs) begin
        if (coal) begin
          t = mq[mq.size()-1];
          t.tgt = n.tgt;
          t.inf = n.inf;
          mq[mq.size()-1] = t;
        end else begin
          mq.push_back(n);
        end
      end
    end
    m_done = done_n;
    @(negedge CLK);
  endtask

  task automatic idle(string name, bit wrr);
    cycle(name, 1'b0, 32'h0, 9'h0, 10'h0, 3'h0, 1'b0, wrr);
  endtask

  task automatic clear_obs();
    obs_acc = 0; obs_wr = 0; obs_clr_wr = 0; obs_done = 0;
    obs_last_clr_idx = -1; obs_clear_cyc = 0;
    obs_tgt.delete();
  endtask

  vec_t vecs[5];
  logic [31:0] pool[4];

  initial begin
    int first_full;
    int sel;
    logic [31:0] pc;
    logic [8:0]  asid;

    vecs[0] = '{32'h0001F800, 9'h005, 10'h155, 3'd2, 7'h00, 3'd0, 6'h3A};
    vecs[1] = '{32'h00001236, 9'h000, 10'h0AA, 3'd1, 7'h23, 3'd3, 6'h02};
    vecs[2] = '{32'hFFFFFFFF, 9'h1FF, 10'h3FF, 3'd7, 7'h7F, 3'd7, 6'h3F};
    vecs[3] = '{32'h00020000, 9'h000, 10'h001, 3'd0, 7'h00, 3'd0, 6'h01};
    vecs[4] = '{32'h0000000E, 9'h040, 10'h200, 3'd4, 7'h00, 3'd7, 6'h00};
    pool[0] = 32'h0001F800;
    pool[1] = 32'h00001236;
    pool[2] = 32'h00ABCDE0;
    pool[3] = 32'h7FFF0002;

    bus.upd_valid = 1'b0; bus.upd_PC = '0; bus.upd_ASID = '0; bus.upd_target = '0;
    bus.upd_info = '0; bus.clr_req = 1'b0; bus.wr_ready = 1'b1;
    clear_obs();
    model_reset();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    chk("reset", 64'(dut_out()), 64'({1'b1, 32'b0}));

    // Field extraction vectors
    for (int i = 0; i < 5; i++) begin
      cycle("vec_in", 1'b1, vecs[i].pc, vecs[i].asid, vecs[i].tgt, vecs[i].inf, 1'b0, 1'b1);
      chk($sformatf("vec%0d", i), 64'(dut_out()),
          64'({1'b1, 1'b0, 1'b1, 1'b0, vecs[i].idx, vecs[i].ent, vecs[i].tag,
               vecs[i].tgt, vecs[i].inf}));
      idle("vec_drain", 1'b1);
    end

    // Backpressure: five offers into a four-deep queue
    clear_obs();
    first_full = -1;
    for (int i = 0; i < 5; i++) begin
      cycle("bp_in", 1'b1, 32'h100 * (i + 1), 9'h0, 10'(i + 1), 3'd0, 1'b0, 1'b0);
      if (!bus.upd_ready && first_full < 0) first_full = i;
    end
    chk("bp_accepted", 64'(obs_acc), 64'd4);
    chk("bp_full_after", 64'(first_full), 64'd3);
    for (int i = 0; i < 6; i++) idle("bp_drain", 1'b1);
    chk("bp_writes", 64'(obs_wr), 64'd4);
    for (int k = 0; k < 4; k++)
      chk("bp_order", 64'(obs_tgt.size() > k ? obs_tgt[k] : 10'h3FF), 64'(k + 1));

    // Sweep with pending updates and wr_ready toggling
    for (int i = 0; i < 3; i++)
      cycle("cl_in", 1'b1, 32'h40 * (i + 1), 9'h1, 10'h7, 3'd1, 1'b0, 1'b0);
    cycle("cl_pulse", 1'b0, 32'h0, 9'h0, 10'h0, 3'h0, 1'b1, 1'b0);
    clear_obs();
    for (int i = 0; i < 600 && obs_done == 0; i++) idle("sweep", (i % 2) == 1);
    chk("sweep_writes", 64'(obs_clr_wr), 64'd128);
    chk("sweep_cycles", 64'(obs_clear_cyc), 64'd256);
    chk("sweep_last_idx", 64'(obs_last_clr_idx), 64'd127);
    chk("sweep_ready", 64'(bus.upd_ready), 64'd1);
    for (int i = 0; i < 5; i++) idle("sweep_post", 1'b1);
    chk("sweep_done_once", 64'(obs_done), 64'd1);
    chk("sweep_no_stale", 64'(obs_wr - obs_clr_wr), 64'd0);

    // Restart mid-sweep
    cycle("rs_pulse", 1'b0, 32'h0, 9'h0, 10'h0, 3'h0, 1'b1, 1'b0);
    clear_obs();
    for (int i = 0; i < 50; i++) idle("rs_run", 1'b1);
    chk("rs_at50", 64'(bus.wr_index), 64'd50);
    cycle("rs_restart", 1'b0, 32'h0, 9'h0, 10'h0, 3'h0, 1'b1, 1'b0);
    chk("rs_idx0", 64'({bus.wr_clear, bus.wr_index}), 64'({1'b1, 7'd0}));
    for (int i = 0; i < 400 && obs_done == 0; i++) idle("rs_sweep", 1'b1);
    for (int i = 0; i < 3; i++) idle("rs_post", 1'b1);
    chk("rs_done_once", 64'(obs_done), 64'd1);
    chk("rs_writes", 64'(obs_clr_wr), 64'd178);

    // Async reset mid-sweep
    cycle("rst_pulse", 1'b0, 32'h0, 9'h0, 10'h0, 3'h0, 1'b1, 1'b0);
    clear_obs();
    for (int i = 0; i < 70; i++) idle("rst_run", 1'b1);
    chk("rst_at70", 64'(bus.wr_index), 64'd70);
    nRST = 1'b0;
    #1;
    chk("rst_vals", 64'(dut_out()), 64'({1'b1, 32'b0}));
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 5; i++) idle("rst_post", 1'b1);
    chk("rst_no_done", 64'(obs_done), 64'd0);

    // Repeated update to the same slot while the port is blocked
    clear_obs();
    cycle("co_a", 1'b1, 32'h00004A52, 9'h033, 10'h010, 3'd1, 1'b0, 1'b0);
    cycle("co_b", 1'b1, 32'h00004A52, 9'h033, 10'h020, 3'd5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle("co_drain", 1'b1);
`ifdef BTB_UPDATE_COALESCE_EN
    chk("co_writes", 64'(obs_wr), 64'd1);
    chk("co_target", 64'(obs_tgt.size() > 0 ? obs_tgt[0] : 10'h3FF), 64'h020);
`else
    chk("co_writes", 64'(obs_wr), 64'd2);
    chk("co_target0", 64'(obs_tgt.size() > 0 ? obs_tgt[0] : 10'h3FF), 64'h010);
    chk("co_target1", 64'(obs_tgt.size() > 1 ? obs_tgt[1] : 10'h3FF), 64'h020);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(3));
      pc = ($urandom_range(3) == 0) ? $urandom : pool[sel];
      asid = ($urandom_range(1) == 1) ? 9'h005 : 9'($urandom);
      cycle("rand", 1'($urandom), pc, asid, 10'($urandom), 3'($urandom),
            $urandom_range(249) == 0, $urandom_range(3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/btb_update_writer.md
Name: btb_update_writer

Overview:
- Write-side counterpart of the BTB tag hash on the predict/lookup path.
- Accepts resolved-branch BTB updates from the branch resolution unit and buffers them in a small FIFO.
- Derives index, entry-within-block and hashed tag from PC+ASID, then drives the BTB array write port.
- Also runs a full-array invalidation sweep on request, e.g. on ASID recycle or fence.

Parameters:
- UPDATE_QUEUE_DEPTH, 4, FIFO entries; power of 2, ≥2.
- BTB_INDEX_WIDTH, 7, set index bits.
- LOG_BTB_NWAY_ENTRIES_PER_BLOCK, 3, entry-within-block select bits.
- BTB_TAG_WIDTH, 6, stored tag bits.
- ASID_WIDTH, 9, ASID bits.
- BTB_TARGET_WIDTH, 10, stored low target bits.
- BTB_INFO_WIDTH, 3, branch type/metadata bits.

Ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- upd_valid  in  1  update request
- upd_ready  out  1  update accepted when valid&&ready
- upd_PC  in  32  branch PC
- upd_ASID  in  ASID_WIDTH  address-space ID
- upd_target  in  BTB_TARGET_WIDTH  target bits
- upd_info  in  BTB_INFO_WIDTH  metadata
- clr_req  in  1  start invalidation sweep (pulse)
- clr_done  out  1  one-cycle pulse, sweep finished
- wr_valid  out  1  array write request
- wr_ready  in  1  array grants write this cycle (low while predict read owns port)
- wr_clear  out  1  invalidate all entries of wr_index
- wr_index  out  BTB_INDEX_WIDTH  set index
- wr_entry  out  LOG_BTB_NWAY_ENTRIES_PER_BLOCK  entry in block
- wr_tag  out  BTB_TAG_WIDTH  hashed tag
- wr_target  out  BTB_TARGET_WIDTH  target
- wr_info  out  BTB_INFO_WIDTH  metadata

Behaviour:
- Field extraction. Let S = BTB_INDEX_WIDTH + LOG_BTB_NWAY_ENTRIES_PER_BLOCK + 1.
  - entry = PC[LOG+1-1:1]
  - index = PC[S-1:LOG+1]
  - tag = PC[S+T-1:S] ^ PC[S+2T-1:S+T] ^ ASID[T-1:0]
  - PC bits above 31 read as 0.
  - This must match the lookup-side hash bit-for-bit.
  - Fields are computed at enqueue; the FIFO stores index/entry/tag/target/info, not PC/ASID.
- FSM states: NORMAL, CLEAR.
- Reset values: state NORMAL, FIFO empty, sweep counter 0, clr_done 0, wr_valid 0, wr_clear 0, all wr_* data 0, upd_ready 1.
- NORMAL:
  - upd_ready = !full. It is registered-state-derived; no combinational path from any input.
  - wr_valid = !empty, with wr_* taken from the FIFO head and wr_clear = 0.
  - Head dequeues on wr_valid&&wr_ready.
  - Latency: an update accepted in cycle N appears on wr_* in cycle N+1 at the earliest. No bypass.
  - Full with a dequeue in the same cycle: upd_ready is still 0 that cycle.
  - Empty with an enqueue in the same cycle: no write issued that cycle.
  - Pointers wrap modulo UPDATE_QUEUE_DEPTH. Full/empty are distinguished by an extra pointer MSB.
- clr_req in any state:
  - Next state CLEAR, counter reset to 0, FIFO flushed (pending updates are stale).
  - An update handshaken in the same cycle as clr_req is discarded.
  - A head write granted in the same cycle as clr_req is considered done.
- CLEAR:
  - upd_ready = 0.
  - wr_valid = 1, wr_clear = 1, wr_index = counter; wr_entry/tag/target/info = 0.
  - Counter increments on wr_ready.
  - On a grant with counter = 2^BTB_INDEX_WIDTH−1: clr_done pulses next cycle, state returns to NORMAL, counter returns to 0.
  - clr_req during CLEAR restarts the sweep at 0; no clr_done for the aborted sweep.
- Async reset mid-sweep or with a non-empty FIFO: everything returns to reset values immediately; no clr_done.

Optional Feature:
- Macro: BTB_UPDATE_COALESCE_EN.
- Defined:
  - An accepted update whose (index, entry, tag) equals the youngest FIFO entry overwrites that entry's target/info instead of enqueueing.
  - Exception: if that youngest entry is the head being dequeued this cycle, the update enqueues normally.
  - upd_ready is unchanged (still !full).
- Undefined: every accepted update enqueues.

Decomposition:
- core_types_pkg holds:
  - the width constants above;
  - typedef btb_update_entry_t {index, entry, tag, target, info};
  - enum btb_update_writer_state_t {NORMAL, CLEAR}.
- One natural sub-module: btb_update_fifo, a generic valid/ready FIFO of btb_update_entry_t with a flush input and a tail-overwrite port used by the coalesce feature.
- Tag hashing stays inline, or reuses the existing shared hash function, so the write and lookup sides cannot diverge.

Test Plan:
- Field extraction:
  - Reset, wr_ready=1; update PC=0x0001F800, ASID=0x005, target=0x155, info=2 -> next cycle wr_valid=1, index=0x00, entry=0, tag=0x3A, target=0x155, info=2.
  - PC=0x00001236, ASID=0 -> index=0x23, entry=3, tag=0x02.
- Backpressure: wr_ready=0; send 5 updates -> 4 accepted, upd_ready=0 from the 4th acceptance. Raise wr_ready -> writes leave in FIFO order, one per cycle.
- Clear with pending updates:
  - 3 queued, pulse clr_req -> queue dropped.
  - 128 writes with wr_clear=1, index 0..127; with wr_ready toggling 1/0 this takes 256 cycles.
  - clr_done pulses once; upd_ready returns to 1.
- Restart and reset during sweep:
  - clr_req at counter=50 -> sweep restarts at index 0; only one clr_done.
  - nRST low at counter=70 -> all outputs at reset values; no clr_done.
- Coalesce (macro defined): wr_ready=0; two updates with the same PC/ASID and targets 0x010 then 0x020 -> single FIFO entry; on release one write with target 0x020. With the macro undefined -> two writes.
